// File: rtl/mc_control_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes and the
// ALU / mux select codes also used by the ALU and datapath.
package mc_control_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_RWB    = 4'd8,
        ST_BEQ    = 4'd9,
        ST_JUMP   = 4'd10,
        ST_HALT   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_ONE     = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
    } ctrl_t;

    // States whose exit to FETCH retires an instruction.
    function automatic logic is_retire_state(input state_t s);
        return (s == ST_MEMWB) || (s == ST_MEMWR) || (s == ST_RWB) ||
               (s == ST_BEQ)   || (s == ST_JUMP);
    endfunction

endpackage

// File: rtl/mc_control.sv
// Multicycle MIPS-style control unit: Moore FSM driving datapath strobes,
// plus a retired-instruction counter.
//
// state  | meaning
// IDLE   | post-reset, one cycle before the first fetch
// FETCH  | read instruction, PC <= PC + 1
// DECODE | read registers, branch target into ALUOut
// MEMADR | effective address for LW/SW
// MEMRD  | data memory read (LW)
// MEMWB  | load result written to rt (LW)
// MEMWR  | data memory write (SW)
// EXEC   | R-type ALU operation
// RWB    | R-type result written to rd
// BEQ    | compare, conditional PC update from ALUOut
// JUMP   | PC <= jump target
// HALT   | parked after an illegal opcode (HALT_ON_ILLEGAL=1)
module mc_control
    import mc_control_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        zero,
    output logic [1:0]  ALUOp,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        RegDst,
    output logic [1:0]  PCSource,
    output logic        pc_en,
    output logic [3:0]  state,
    output logic        halted,
    output logic [31:0] instr_cnt
);

    state_t      state_q;
    state_t      state_d;
    ctrl_t       ctrl;
    logic [31:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_BEQ:       state_d = ST_BEQ;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;
                endcase
            end
            ST_MEMADR: state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  state_d = ST_MEMWB;
            ST_EXEC:   state_d = ST_RWB;
            ST_MEMWB, ST_MEMWR, ST_RWB, ST_BEQ, ST_JUMP: state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.pc_write  = 1'b1;
            end
            ST_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_dst    = 1'b1;
            end
            ST_BEQ: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REGB;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

    // Counter resets with the FSM, so an aborted instruction is never counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (is_retire_state(state_q)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign PCSource    = ctrl.pc_source;
    assign pc_en       = ctrl.pc_write | (ctrl.pc_write_cond & zero);
    assign state       = state_q;
    assign halted      = (state_q == ST_HALT);
    assign instr_cnt   = cnt_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: the driver queues the expected outputs of
// each cycle, a monitor pops and compares them before the next rising edge.
module tb_mc_control;

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] BQ  = 6'b000100;
    localparam logic [5:0] JP  = 6'b000010;
    localparam logic [5:0] ILL = 6'b111111;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic [5:0] op0 = LW;
    logic [5:0] op1 = ILL;
    logic zero = 1'b0;

    logic [1:0]  aluop0, srcb0, pcs0, aluop1, srcb1, pcs1;
    logic        srca0, pcw0, pcwc0, iord0, mr0, mw0, irw0, m2r0, rw0, rd0, pcen0, halt0;
    logic        srca1, pcw1, pcwc1, iord1, mr1, mw1, irw1, m2r1, rw1, rd1, pcen1, halt1;
    logic [3:0]  st0, st1;
    logic [31:0] cnt0, cnt1;

    mc_control #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .rst(rst0), .opcode(op0), .zero(zero),
        .ALUOp(aluop0), .ALUSrcA(srca0), .ALUSrcB(srcb0), .PCWrite(pcw0),
        .PCWriteCond(pcwc0), .IorD(iord0), .MemRead(mr0), .MemWrite(mw0),
        .IRWrite(irw0), .MemtoReg(m2r0), .RegWrite(rw0), .RegDst(rd0),
        .PCSource(pcs0), .pc_en(pcen0), .state(st0), .halted(halt0), .instr_cnt(cnt0)
    );

    mc_control #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .opcode(op1), .zero(zero),
        .ALUOp(aluop1), .ALUSrcA(srca1), .ALUSrcB(srcb1), .PCWrite(pcw1),
        .PCWriteCond(pcwc1), .IorD(iord1), .MemRead(mr1), .MemWrite(mw1),
        .IRWrite(irw1), .MemtoReg(m2r1), .RegWrite(rw1), .RegDst(rd1),
        .PCSource(pcs1), .pc_en(pcen1), .state(st1), .halted(halt1), .instr_cnt(cnt1)
    );

    logic [17:0] act0, act1;
    assign act0 = {aluop0, srca0, srcb0, pcw0, pcwc0, iord0, mr0, mw0, irw0,
                   m2r0, rw0, rd0, pcs0, pcen0, halt0};
    assign act1 = {aluop1, srca1, srcb1, pcw1, pcwc1, iord1, mr1, mw1, irw1,
                   m2r1, rw1, rd1, pcs1, pcen1, halt1};

    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        int          phase;
        logic [3:0]  st;
        logic [17:0] ctl;
        logic [31:0] cnt;
        string       tag;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Expected strobes per state, written straight from the state descriptions.
    function automatic logic [17:0] exp_ctrl(input logic [3:0] s, input logic z);
        logic [1:0] aop, srcb, pcs;
        logic srca, pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, h;
        aop = 2'b00; srcb = 2'b00; pcs = 2'b00;
        srca = 0; pcw = 0; pcwc = 0; iord = 0; mr = 0; mw = 0; irw = 0;
        m2r = 0; rw = 0; rd = 0; h = 0;
        case (s)
            4'd1:  begin mr = 1; irw = 1; srcb = 2'b01; pcw = 1; end
            4'd2:  begin srcb = 2'b11; end
            4'd3:  begin srca = 1; srcb = 2'b10; end
            4'd4:  begin mr = 1; iord = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin mw = 1; iord = 1; end
            4'd7:  begin srca = 1; aop = 2'b10; end
            4'd8:  begin rw = 1; rd = 1; end
            4'd9:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            4'd10: begin pcw = 1; pcs = 2'b10; end
            4'd11: begin h = 1; end
            default: ;
        endcase
        return {aop, srca, srcb, pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, pcs,
                pcw | (pcwc & z), h};
    endfunction

    function automatic exp_t mk(input int sel, input int ph, input logic [3:0] s,
                                input logic z, input logic [31:0] c, input string tag);
        exp_t e;
        e.sel = sel; e.phase = ph; e.st = s; e.ctl = exp_ctrl(s, z); e.cnt = c; e.tag = tag;
        return e;
    endfunction

    task automatic cyc(input int sel, input logic r, input logic [5:0] op, input logic z,
                       input logic [3:0] s, input logic [31:0] c, input string tag);
        @(negedge clk);
        if (sel == 0) begin rst0 = r; op0 = op; end
        else begin rst1 = r; op1 = op; end
        zero = z;
        q.push_back(mk(sel, 0, s, z, c, tag));
    endtask

    task automatic check_phase(input int ph);
        exp_t e;
        logic [3:0]  a_st;
        logic [17:0] a_ctl;
        logic [31:0] a_cnt;
        if (q.size() > 0 && q[0].phase == ph) begin
            e = q.pop_front();
            a_st  = (e.sel == 0) ? st0 : st1;
            a_ctl = (e.sel == 0) ? act0 : act1;
            a_cnt = (e.sel == 0) ? cnt0 : cnt1;
            checks++;
            if (a_st !== e.st) begin
                failures++;
                $display("FAIL %s state: got %0d expected %0d", e.tag, a_st, e.st);
            end
            checks++;
            if (a_ctl !== e.ctl) begin
                failures++;
                $display("FAIL %s ctrl: got %b expected %b", e.tag, a_ctl, e.ctl);
            end
            checks++;
            if (a_cnt !== e.cnt) begin
                failures++;
                $display("FAIL %s instr_cnt: got %h expected %h", e.tag, a_cnt, e.cnt);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2 check_phase(0);
            #2 check_phase(1);
        end
    end

    initial begin
        // LW after reset
        cyc(0, 1, LW, 0, 4'd0, 0, "rst_hold");
        cyc(0, 0, LW, 0, 4'd0, 0, "idle");
        cyc(0, 0, LW, 0, 4'd1, 0, "lw_fetch");
        cyc(0, 0, LW, 0, 4'd2, 0, "lw_decode");
        cyc(0, 0, LW, 0, 4'd3, 0, "lw_memadr");
        cyc(0, 0, LW, 0, 4'd4, 0, "lw_memrd");
        cyc(0, 0, LW, 0, 4'd5, 0, "lw_memwb");
        // SW then RTYPE
        cyc(0, 0, SW, 0, 4'd1, 1, "sw_fetch");
        cyc(0, 0, SW, 0, 4'd2, 1, "sw_decode");
        cyc(0, 0, SW, 0, 4'd3, 1, "sw_memadr");
        cyc(0, 0, SW, 0, 4'd6, 1, "sw_memwr");
        cyc(0, 0, RT, 0, 4'd1, 2, "rt_fetch");
        cyc(0, 0, RT, 0, 4'd2, 2, "rt_decode");
        cyc(0, 0, RT, 0, 4'd7, 2, "rt_exec");
        cyc(0, 0, RT, 0, 4'd8, 2, "rt_rwb");
        // BEQ taken then not taken
        cyc(0, 0, BQ, 1, 4'd1, 3, "beq1_fetch");
        cyc(0, 0, BQ, 1, 4'd2, 3, "beq1_decode");
        cyc(0, 0, BQ, 1, 4'd9, 3, "beq1_taken");
        cyc(0, 0, BQ, 0, 4'd1, 4, "beq0_fetch");
        cyc(0, 0, BQ, 0, 4'd2, 4, "beq0_decode");
        cyc(0, 0, BQ, 0, 4'd9, 4, "beq0_nottaken");
        // illegal opcode returns to FETCH without retiring
        cyc(0, 0, ILL, 0, 4'd1, 5, "ill_fetch");
        cyc(0, 0, ILL, 0, 4'd2, 5, "ill_decode");
        cyc(0, 0, LW, 0, 4'd1, 5, "ill_refetch");
        cyc(0, 0, LW, 0, 4'd2, 5, "lw2_decode");
        cyc(0, 0, LW, 0, 4'd3, 5, "lw2_memadr");
        // asynchronous reset in MEMRD, checked before the next rising edge
        cyc(0, 0, LW, 0, 4'd4, 5, "lw2_memrd");
        #3 rst0 = 1'b1;
        q.push_back(mk(0, 1, 4'd0, 0, 0, "async_rst"));
        cyc(0, 0, JP, 0, 4'd0, 0, "rst_release_idle");
        cyc(0, 0, JP, 0, 4'd1, 0, "j_fetch");
        cyc(0, 0, JP, 0, 4'd2, 0, "j_decode");
        // counter wrap while retiring J
        @(negedge clk);
        force dut0.cnt_q = 32'hFFFF_FFFF;
        #1 release dut0.cnt_q;
        q.push_back(mk(0, 0, 4'd10, 0, 32'hFFFF_FFFF, "j_jump_preset"));
        cyc(0, 0, LW, 0, 4'd1, 0, "wrap_fetch");
        cyc(0, 1, LW, 0, 4'd0, 0, "dut0_park");

        // HALT_ON_ILLEGAL=1 instance
        cyc(1, 1, ILL, 0, 4'd0, 0, "h_rst");
        cyc(1, 0, ILL, 0, 4'd0, 0, "h_idle");
        cyc(1, 0, ILL, 0, 4'd1, 0, "h_fetch");
        cyc(1, 0, ILL, 0, 4'd2, 0, "h_decode");
        cyc(1, 0, ILL, 0, 4'd11, 0, "h_halt0");
        cyc(1, 0, LW, 1, 4'd11, 0, "h_halt1");
        cyc(1, 0, JP, 0, 4'd11, 0, "h_halt2");
        cyc(1, 1, LW, 0, 4'd0, 0, "h_rst_again");
        cyc(1, 0, LW, 0, 4'd0, 0, "h_idle2");
        cyc(1, 0, LW, 0, 4'd1, 0, "h_fetch2");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #5;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter HALT_ON_ILLEGAL, default 0: when 1, an unknown opcode parks the FSM in HALT; when 0, it returns to FETCH.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 opcode  input  6  IR[31:26] of the current instruction, sampled in DECODE and later states.
REQ-005 zero  input  1  combinational ALU zero flag (result==0).
REQ-006 ALUOp  output  2  ALU control: 00 add, 01 sub, 10 funct-decoded.
REQ-007 ALUSrcA  output  1  ALU A select: 0 PC, 1 regA.
REQ-008 ALUSrcB  output  2  ALU B select: 00 regB, 01 constant 1, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-009 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst  output  1 each  datapath strobes and selects.
REQ-010 PCSource  output  2  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 pc_en  output  1  PCWrite | (PCWriteCond & zero).
REQ-012 state  output  4  current state encoding, for debug.
REQ-013 halted  output  1  high while in HALT.
REQ-014 instr_cnt  output  32  count of retired instructions.

Function
REQ-015 States and encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BEQ=9, JUMP=10, HALT=11.
REQ-016 Opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, J 000010; every other value is illegal.
REQ-017 Transitions: IDLE->FETCH; FETCH->DECODE; DECODE->MEMADR (LW/SW), EXEC (RTYPE), BEQ, JUMP, or illegal handling per REQ-001.
REQ-018 Further transitions: MEMADR->MEMRD (LW) or MEMWR (SW); MEMRD->MEMWB; EXEC->RWB; MEMWB, MEMWR, RWB, BEQ and JUMP->FETCH; HALT->HALT.
REQ-019 Outputs are Moore (decoded from state only), except pc_en; every strobe and select not listed for a state is 0.
REQ-020 FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=1.
REQ-021 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target latched into ALUOut).
REQ-022 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-023 MEMRD: MemRead=1, IorD=1. MEMWR: MemWrite=1, IorD=1. MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
REQ-024 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. RWB: RegWrite=1, MemtoReg=0, RegDst=1.
REQ-025 BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; pc_en follows zero in the same cycle.
REQ-026 JUMP: PCWrite=1, PCSource=10.
REQ-027 Latencies: LW 5 cycles; SW and RTYPE 4 cycles; BEQ and J 3 cycles (FETCH through the last state inclusive).
REQ-028 instr_cnt increments by 1 on each transition from MEMWB, MEMWR, RWB, BEQ or JUMP to FETCH.
REQ-029 instr_cnt wraps from 0xFFFFFFFF to 0; illegal opcodes and HALT never increment it.
REQ-030 With HALT_ON_ILLEGAL=0, an illegal opcode goes DECODE->FETCH with no write strobe asserted.

Reset
REQ-031 rst asserted forces state=IDLE immediately, independent of clk; every output is 0 while rst is high, including pc_en and instr_cnt.
REQ-032 rst asserted mid-instruction (in any state) aborts that instruction without a count; after rst is released, FETCH follows exactly one IDLE cycle.

Structure
REQ-033 State encodings, opcode constants and the ALUOp/ALUSrcB/PCSource code values belong in a shared package, which the ALU and datapath also use.
REQ-034 Single module with no sub-modules: a state register with next-state logic, a Moore output decoder, and the counter.

Verification
REQ-035 Reset with opcode=100011, then stream LW -> states 0,1,2,3,4,5,1; MemWB cycle shows RegWrite=1 and MemtoReg=1; instr_cnt=1.
REQ-036 SW then RTYPE -> states 1,2,3,6,1,2,7,8,1; MemWrite=1 only in MEMWR; ALUOp=10 only in EXEC; instr_cnt=2.
REQ-037 BEQ with zero=1, then BEQ with zero=0 -> pc_en=1 in the first BEQ cycle and 0 in the second; PCSource=01 in both; instr_cnt=2.
REQ-038 Opcode 111111 with HALT_ON_ILLEGAL=0 -> DECODE->FETCH, no strobes, count unchanged; with HALT_ON_ILLEGAL=1 -> HALT, halted=1, held until rst.
REQ-039 rst pulsed asynchronously in MEMRD -> state=0 and all outputs 0 before the next edge; FETCH follows one cycle after release.
REQ-040 Force instr_cnt to 0xFFFFFFFF, then retire J -> instr_cnt=0.
